// File: rtl/dual_datapath_dispatcher_if.sv
// Fetch-side and decode-side signal bundle for the scalar/vector dispatcher.
// The master modport is the fetch/decode environment; the dispatcher uses the slave modport.
interface dual_datapath_dispatcher_if #(
  parameter int N     = 24,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [N-1:0]  in_instruction;
  logic          in_ready;
  logic          flush;
  logic          scalar_stall;
  logic          vector_stall;
  logic [N-1:0]  scalar_instr;
  logic          scalar_valid;
  logic [N-1:0]  vector_instr;
  logic          vector_valid;
  logic [CW-1:0] scalar_count;
  logic [CW-1:0] vector_count;

  modport master (
    output in_valid, in_instruction, flush, scalar_stall, vector_stall,
    input  in_ready, scalar_instr, scalar_valid, vector_instr, vector_valid,
           scalar_count, vector_count
  );

  modport slave (
    input  in_valid, in_instruction, flush, scalar_stall, vector_stall,
    output in_ready, scalar_instr, scalar_valid, vector_instr, vector_valid,
           scalar_count, vector_count
  );
endinterface

// File: rtl/dual_datapath_dispatcher.sv
// Classifies fetch words as scalar or vector and queues each class in its own FIFO,
// feeding a registered output per datapath that advances under its own stall.
module dual_datapath_dispatcher #(
  parameter int             N           = 24,
  parameter int             DEPTH       = 4,
  parameter logic [7:0]     VEC_OP_MASK = 8'b0000_0111,
  parameter logic [N-1:0]   DNT_WORD    = 24'h100004
) (
  input  logic                        clk,
  input  logic                        rst,
  dual_datapath_dispatcher_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]          w_opcode;
  logic                w_vbit;
  logic                w_is_vec;
  logic                w_ready;
  logic [1:0]          w_push;
  logic [1:0]          w_stall;
  logic [1:0][CW-1:0]  w_count;
  logic [1:0][N-1:0]   w_instr;
  logic [1:0]          w_valid;

  assign w_opcode = bus.in_instruction[N-1:N-3];
  assign w_vbit   = bus.in_instruction[N-4];
  assign w_is_vec = w_vbit & VEC_OP_MASK[w_opcode];

  // Readiness looks only at the target FIFO's current count, so a same-cycle pop never frees a slot.
  assign w_ready  = ~bus.flush & (w_count[w_is_vec] != FULL);
  assign w_push[0] = bus.in_valid & w_ready & ~w_is_vec;
  assign w_push[1] = bus.in_valid & w_ready &  w_is_vec;
  assign w_stall   = {bus.vector_stall, bus.scalar_stall};

  // Index 0 is the scalar datapath, index 1 the vector datapath.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_path
      logic [N-1:0]  r_mem [DEPTH];
      logic [PW-1:0] r_rd;
      logic [PW-1:0] r_wr;
      logic [CW-1:0] r_count;
      logic [N-1:0]  r_instr;
      logic          r_valid;
      logic          w_empty;
      logic          w_pop;

      assign w_empty = (r_count == '0);
      assign w_pop   = ~bus.flush & ~w_stall[gi] & ~w_empty;

      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wr] <= bus.in_instruction;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rd    <= '0;
          r_wr    <= '0;
          r_count <= '0;
        end else if (bus.flush) begin
          r_rd    <= '0;
          r_wr    <= '0;
          r_count <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wr <= r_wr + 1'b1;
          end
          if (w_pop) begin
            r_rd <= r_rd + 1'b1;
          end
          if (w_push[gi] && !w_pop) begin
            r_count <= r_count + 1'b1;
          end else if (!w_push[gi] && w_pop) begin
            r_count <= r_count - 1'b1;
          end
        end
      end

      // Output only ever loads from the FIFO head; a fresh push is not visible until the next edge.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_instr <= DNT_WORD;
          r_valid <= 1'b0;
        end else if (bus.flush) begin
          r_instr <= DNT_WORD;
          r_valid <= 1'b0;
        end else if (!w_stall[gi]) begin
          if (!w_empty) begin
            r_instr <= r_mem[r_rd];
            r_valid <= 1'b1;
          end else begin
            r_instr <= DNT_WORD;
            r_valid <= 1'b0;
          end
        end
      end

      assign w_count[gi] = r_count;
      assign w_instr[gi] = r_instr;
      assign w_valid[gi] = r_valid;
    end
  endgenerate

  assign bus.in_ready     = w_ready;
  assign bus.scalar_instr = w_instr[0];
  assign bus.scalar_valid = w_valid[0];
  assign bus.scalar_count = w_count[0];
  assign bus.vector_instr = w_instr[1];
  assign bus.vector_valid = w_valid[1];
  assign bus.vector_count = w_count[1];
endmodule
